inst_sweep_sequencer: RTL and testbench

- Sequences a bank of N_INST child instances, inst_0..inst_{N_INST-1}, one at a time in index order.
- Each enabled child receives a one-cycle start pulse. The sequencer then waits for that child's done, or a timeout, and moves to the next child.
- Sits in the parent module beside the child instances and reports per-child failure and end-of-sweep status.

---
 rtl/inst_seq_pkg.sv | 30 +++
 rtl/inst_sweep_sequencer_if.sv | 30 +++
 rtl/inst_seq_timer.sv | 30 +++
 rtl/inst_sweep_sequencer.sv | 110 +++++++++++
 tb/tb_inst_sweep_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_seq_pkg.sv
// Shared types and defaults for the instance sweep sequencer and its timer.
// State encodings are kept as plain constants so older code can still match on them.
package inst_seq_pkg;

   localparam int N_INST_DEF  = 10;
   localparam int TIMEOUT_DEF = 200;
   localparam int TMR_W_DEF   = 8;

   // Width of an index that must also hold the one-past-the-end value N_INST.
   function automatic int idx_width(input int n_inst);
      return $clog2(n_inst + 1);
   endfunction

   localparam int IDX_W = idx_width(N_INST_DEF);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_SELECT = S_SELECT,
      ST_START  = S_START,
      ST_WAIT   = S_WAIT,
      ST_FINISH = S_FINISH
   } state_t;

endpackage

// File: rtl/inst_sweep_sequencer_if.sv
// Request/status bundle between the parent logic and the sweep sequencer.
// The master drives the sweep request and child done lines; the slave is the sequencer.
interface inst_sweep_sequencer_if
   import inst_seq_pkg::*;
#(
   parameter int N_INST = N_INST_DEF
) ();

   localparam int IW = idx_width(N_INST);

   logic              run_i;
   logic [N_INST-1:0] mask_i;
   logic [N_INST-1:0] done_i;
   logic [N_INST-1:0] start_o;
   logic              busy_o;
   logic [IW-1:0]     cur_idx_o;
   logic [N_INST-1:0] fail_o;
   logic              sweep_done_o;

   modport master (
      output run_i, mask_i, done_i,
      input  start_o, busy_o, cur_idx_o, fail_o, sweep_done_o
   );

   modport slave (
      input  run_i, mask_i, done_i,
      output start_o, busy_o, cur_idx_o, fail_o, sweep_done_o
   );

endinterface

// File: rtl/inst_seq_timer.sv
// Per-child WAIT timer: clears on START, counts while waiting, and flags the last
// allowed cycle so the sequencer can mark the child failed.
module inst_seq_timer
   import inst_seq_pkg::*;
#(
   parameter int TMR_W   = TMR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [TMR_W-1:0] r_count;

   // NOTE: sequential state is updated only with non-blocking assignments so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + TMR_W'(1);
      end
   end

   assign o_tc = (r_count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/inst_sweep_sequencer.sv
// Walks a bank of child instances in index order: one start pulse per enabled child,
// then waits for its done or a timeout before moving on; reports sticky per-child fails.
module inst_sweep_sequencer
   import inst_seq_pkg::*;
#(
   parameter int N_INST  = N_INST_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TMR_W   = TMR_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   inst_sweep_sequencer_if.slave   bus
);

   localparam int IW    = idx_width(N_INST);
   localparam int EXT_W = 1 << IW;

   state_t            r_state;
   logic [IW-1:0]     r_idx;
   logic [N_INST-1:0] r_mask;
   logic [N_INST-1:0] r_fail;

   logic [EXT_W-1:0]  w_mask_ext;
   logic [EXT_W-1:0]  w_done_ext;
   logic [N_INST-1:0] w_idx_onehot;
   logic              w_cur_en;
   logic              w_cur_done;
   logic              w_last;
   logic              w_tmr_clr;
   logic              w_tmr_en;
   logic              w_tmr_tc;

   // Zero-padding to a power of two lets idx==N_INST read as "disabled, not done".
   assign w_mask_ext   = EXT_W'(r_mask);
   assign w_done_ext   = EXT_W'(bus.done_i);
   assign w_cur_en     = w_mask_ext[r_idx];
   assign w_cur_done   = w_done_ext[r_idx];
   assign w_last       = (r_idx == IW'(N_INST));
   assign w_idx_onehot = N_INST'(1) << r_idx;

   assign w_tmr_clr = (r_state == ST_START);
   assign w_tmr_en  = (r_state == ST_WAIT) && !w_cur_done && !w_tmr_tc;

   inst_seq_timer #(
      .TMR_W   (TMR_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_tmr_clr),
      .i_en  (w_tmr_en),
      .o_tc  (w_tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_mask  <= '0;
         r_fail  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.run_i) begin
                  r_mask  <= bus.mask_i;
                  r_idx   <= '0;
                  r_fail  <= '0;
                  r_state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_last) begin
                  r_state <= ST_FINISH;
               end else if (!w_cur_en) begin
                  r_idx <= r_idx + IW'(1);
               end else begin
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving on the terminal cycle still counts as success.
               if (w_cur_done) begin
                  r_idx   <= r_idx + IW'(1);
                  r_state <= ST_SELECT;
               end else if (w_tmr_tc) begin
                  r_fail  <= r_fail | w_idx_onehot;
                  r_idx   <= r_idx + IW'(1);
                  r_state <= ST_SELECT;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.start_o      = (r_state == ST_START) ? w_idx_onehot : '0;
   assign bus.busy_o       = (r_state != ST_IDLE);
   assign bus.sweep_done_o = (r_state == ST_FINISH);
   assign bus.cur_idx_o    = r_idx;
   assign bus.fail_o       = r_fail;

endmodule

// File: tb/tb_inst_sweep_sequencer.sv
// Directed bench for the sweep sequencer with TIMEOUT=4; a small responder model
// plays the children, answering a configurable number of cycles after each start pulse.
module tb_inst_sweep_sequencer;
   import inst_seq_pkg::*;

   localparam int N  = 10;
   localparam int TO = 4;
   localparam int TW = 8;

   logic clk = 1'b0;
   logic rst;

   inst_sweep_sequencer_if #(.N_INST(N)) sif ();

   inst_sweep_sequencer #(
      .N_INST  (N),
      .TIMEOUT (TO),
      .TMR_W   (TW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Child responder model.
   logic [N-1:0] resp_en   = '0;
   logic [N-1:0] resp_done = '0;
   logic [N-1:0] man_done  = '0;
   int           resp_dly[N];
   int           cnt[N];

   assign sif.done_i = resp_done | man_done;

   always @(negedge clk) begin
      resp_done = '0;
      for (int k = 0; k < N; k++) begin
         if (rst) begin
            cnt[k] = 0;
         end else begin
            if (cnt[k] > 0) begin
               cnt[k] = cnt[k] - 1;
               if (cnt[k] == 0) resp_done[k] = 1'b1;
            end
            if (sif.start_o[k] && resp_en[k]) cnt[k] = resp_dly[k];
         end
      end
   end

   // Output monitor.
   int start_q[$];
   int start_c[$];
   int sd_cnt    = 0;
   int multi_hot = 0;

   always @(negedge clk) begin
      if (sif.start_o != '0) begin
         start_q.push_back(int'(sif.start_o));
         start_c.push_back(cyc);
         if (!$onehot(sif.start_o)) multi_hot++;
      end
      if (sif.sweep_done_o) sd_cnt++;
   end

   task automatic set_resp(input logic [N-1:0] en, input int dly);
      resp_en = en;
      for (int k = 0; k < N; k++) resp_dly[k] = dly;
   endtask

   task automatic clear_log();
      start_q.delete();
      start_c.delete();
      sd_cnt    = 0;
      multi_hot = 0;
   endtask

   // One-cycle run request; sel is the cycle number of the first SELECT cycle.
   task automatic do_run(input logic [N-1:0] mask, output int sel);
      @(negedge clk);
      clear_log();
      sif.mask_i = mask;
      sif.run_i  = 1'b1;
      @(negedge clk);
      sif.run_i  = 1'b0;
      sif.mask_i = ~mask;
      sel = cyc;
   endtask

   task automatic wait_sweep(input int bound, output int fin);
      fin = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (sif.sweep_done_o) begin
            fin = cyc;
            break;
         end
      end
   endtask

   task automatic check_starts(input string name, input int sel,
                               input int exp_v[$], input int exp_c[$]);
      n_tests++;
      if (start_q.size() != exp_v.size()) begin
         n_fail++;
         $display("FAIL %s_count: got %0d start pulses, expected %0d", name, start_q.size(), exp_v.size());
      end else begin
         for (int k = 0; k < exp_v.size(); k++) begin
            n_tests++;
            if (start_q[k] != exp_v[k] || start_c[k] != sel + exp_c[k]) begin
               n_fail++;
               $display("FAIL %s_start%0d: got 0x%03h at sel+%0d, expected 0x%03h at sel+%0d",
                        name, k, start_q[k], start_c[k] - sel, exp_v[k], exp_c[k]);
            end
         end
      end
      n_tests++;
      if (multi_hot != 0) begin
         n_fail++;
         $display("FAIL %s_onehot: got %0d multi-hot cycles, expected 0", name, multi_hot);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sif.run_i  = 1'b0;
      sif.mask_i = '0;
      man_done   = '0;
      set_resp('0, 1);
      repeat (3) @(negedge clk);
      n_tests++;
      if (sif.start_o !== '0 || sif.busy_o !== 1'b0 || sif.cur_idx_o !== '0 ||
          sif.fail_o !== '0 || sif.sweep_done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got start=%h busy=%b idx=%0d fail=%h done=%b, expected all 0",
                  sif.start_o, sif.busy_o, sif.cur_idx_o, sif.fail_o, sif.sweep_done_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_sweep();
      int sel, fin;
      int ev[$], ec[$];
      set_resp('1, 2);
      do_run(10'h3FF, sel);
      n_tests++;
      if (sif.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_busy_rise: got %b, expected 1", sif.busy_o);
      end
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 41) begin
         n_fail++;
         $display("FAIL full_done_cyc: got sel+%0d, expected sel+41", fin - sel);
      end
      for (int k = 0; k < N; k++) begin
         ev.push_back(1 << k);
         ec.push_back(1 + 4 * k);
      end
      check_starts("full", sel, ev, ec);
      n_tests++;
      if (sif.fail_o !== '0) begin
         n_fail++;
         $display("FAIL full_fail: got %h, expected 000", sif.fail_o);
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (sif.busy_o !== 1'b0 || sd_cnt != 1) begin
         n_fail++;
         $display("FAIL full_end: got busy=%b pulses=%0d, expected busy=0 pulses=1", sif.busy_o, sd_cnt);
      end
   endtask

   task automatic test_sparse_mask();
      int sel, fin;
      int ev[$] = '{32'h001, 32'h004, 32'h200};
      int ec[$] = '{1, 5, 14};
      set_resp('1, 1);
      do_run(10'h205, sel);
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 17) begin
         n_fail++;
         $display("FAIL sparse_done_cyc: got sel+%0d, expected sel+17", fin - sel);
      end
      check_starts("sparse", sel, ev, ec);
   endtask

   task automatic test_timeout();
      int sel, fin;
      int ev[$] = '{32'h008, 32'h010};
      int ec[$] = '{4, 10};
      set_resp(10'h3F7, 1);
      do_run(10'h018, sel);
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 18) begin
         n_fail++;
         $display("FAIL timeout_done_cyc: got sel+%0d, expected sel+18", fin - sel);
      end
      check_starts("timeout", sel, ev, ec);
      n_tests++;
      if (sif.fail_o !== 10'h008) begin
         n_fail++;
         $display("FAIL timeout_fail: got %h, expected 008", sif.fail_o);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (sif.fail_o !== 10'h008) begin
         n_fail++;
         $display("FAIL timeout_fail_hold: got %h, expected 008", sif.fail_o);
      end
   endtask

   task automatic test_late_done();
      int sel, fin;
      int ev[$] = '{32'h002};
      int ec[$] = '{2};
      set_resp('1, 1);
      resp_dly[1] = 4;
      do_run(10'h002, sel);
      n_tests++;
      if (sif.fail_o !== '0) begin
         n_fail++;
         $display("FAIL late_fail_clear: got %h, expected 000", sif.fail_o);
      end
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 16) begin
         n_fail++;
         $display("FAIL late_done_cyc: got sel+%0d, expected sel+16", fin - sel);
      end
      check_starts("late", sel, ev, ec);
      n_tests++;
      if (sif.fail_o !== '0) begin
         n_fail++;
         $display("FAIL late_fail: got %h, expected 000", sif.fail_o);
      end
   endtask

   task automatic test_foreign_done();
      int sel, fin;
      bit seen;
      int ev[$] = '{32'h002, 32'h004};
      int ec[$] = '{2, 8};
      set_resp(10'h3FD, 1);
      man_done = 10'h004;
      do_run(10'h006, sel);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sif.cur_idx_o == 2) begin
            seen = 1'b1;
            break;
         end
      end
      man_done = '0;
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL foreign_reach_idx2: got idx=%0d, expected 2 within 50 cycles", sif.cur_idx_o);
      end
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 18) begin
         n_fail++;
         $display("FAIL foreign_done_cyc: got sel+%0d, expected sel+18", fin - sel);
      end
      check_starts("foreign", sel, ev, ec);
      n_tests++;
      if (sif.fail_o !== 10'h002) begin
         n_fail++;
         $display("FAIL foreign_fail: got %h, expected 002", sif.fail_o);
      end
   endtask

   task automatic test_back_to_back();
      int sel, fin;
      set_resp('1, 2);
      do_run(10'h3FF, sel);
      repeat (10) @(negedge clk);
      sif.mask_i = 10'h001;
      sif.run_i  = 1'b1;
      @(negedge clk);
      sif.run_i  = 1'b0;
      wait_sweep(200, fin);
      n_tests++;
      if (fin != sel + 41) begin
         n_fail++;
         $display("FAIL b2b_done_cyc: got sel+%0d, expected sel+41", fin - sel);
      end
      repeat (6) @(negedge clk);
      n_tests++;
      if (sd_cnt != 1 || start_q.size() != N || sif.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_no_requeue: got pulses=%0d starts=%0d busy=%b, expected 1/10/0",
                  sd_cnt, start_q.size(), sif.busy_o);
      end
   endtask

   task automatic test_zero_mask();
      int sel, fin;
      do_run(10'h000, sel);
      wait_sweep(100, fin);
      n_tests++;
      if (fin != sel + 11) begin
         n_fail++;
         $display("FAIL zero_done_cyc: got sel+%0d, expected sel+11", fin - sel);
      end
      n_tests++;
      if (start_q.size() != 0 || sif.fail_o !== '0) begin
         n_fail++;
         $display("FAIL zero_no_start: got starts=%0d fail=%h, expected 0/000", start_q.size(), sif.fail_o);
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (sif.cur_idx_o !== 4'd10 || sif.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle_idx: got idx=%0d busy=%b, expected idx=10 busy=0", sif.cur_idx_o, sif.busy_o);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int sel;
      bit seen;
      set_resp(10'h3DB, 1);
      do_run(10'h3FF, sel);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sif.start_o[5]) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen || sif.fail_o !== 10'h004) begin
         n_fail++;
         $display("FAIL rstmid_reach5: got seen=%b fail=%h, expected 1/004", seen, sif.fail_o);
      end
      @(negedge clk);
      n_tests++;
      if (sif.cur_idx_o !== 4'd5 || sif.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_wait5: got idx=%0d busy=%b, expected 5/1", sif.cur_idx_o, sif.busy_o);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (sif.start_o !== '0 || sif.busy_o !== 1'b0 || sif.cur_idx_o !== '0 ||
          sif.fail_o !== '0 || sif.sweep_done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got start=%h busy=%b idx=%0d fail=%h done=%b, expected all 0",
                  sif.start_o, sif.busy_o, sif.cur_idx_o, sif.fail_o, sif.sweep_done_o);
      end
      rst = 1'b0;
      clear_log();
      repeat (20) @(negedge clk);
      n_tests++;
      if (start_q.size() != 0 || sd_cnt != 0 || sif.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_quiet: got starts=%0d pulses=%0d busy=%b, expected 0/0/0",
                  start_q.size(), sd_cnt, sif.busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_sparse_mask();
      test_timeout();
      test_late_done();
      test_foreign_done();
      test_back_to_back();
      test_zero_mask();
      test_reset_mid_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
